mem_port_arbiter: RTL and testbench

Sequences a single shared memory port between the instruction-fetch requester and the load/store requester of the RISC-V core, replacing separate imem/dmem instances with one memory. Arbitrates with data priority and fetch anti-starvation, tracks outstanding reads over a fixed memory latency, and routes read data back to the issuing requester.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and
// load/store. Data requests win unless fetch has been starved for
// STARVE_LIMIT consecutive data grants. Reads are tracked for MEM_LATENCY
// cycles and the returned data is steered back to whichever side issued it.
module mem_port_arbiter #(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [AWIDTH-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [AWIDTH-1:0] d_addr_i,
  input  logic [DWIDTH-1:0] d_wdata_i,
  input  logic [2:0]        d_funct3_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic [AWIDTH-1:0] mem_addr_o,
  output logic [DWIDTH-1:0] mem_data_o,
  output logic              mem_read_en_o,
  output logic              mem_write_en_o,
  output logic [2:0]        mem_funct3_o,
  input  logic [DWIDTH-1:0] mem_data_i,
  output logic              busy_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LATENCY - 1);

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic [2:0] lat_cnt;
  logic       owner_data;   // 1 = outstanding read belongs to load/store side
  logic       fetch_wins;
  logic       read_issue;
  logic       read_done;

  assign fetch_wins = if_req_i && (!d_req_i || (starve_cnt == STARVE_MAX));
  assign read_issue = if_gnt_o || (d_gnt_o && !d_we_i);
  assign read_done  = (state == S_WAIT) && (lat_cnt == 3'd0);
  assign busy_o     = (state == S_WAIT);

  // Next-state and grant/memory-port decode; grants only from IDLE.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    state_nxt      = state;
    if_gnt_o       = 1'b0;
    d_gnt_o        = 1'b0;
    mem_addr_o     = '0;
    mem_data_o     = '0;
    mem_read_en_o  = 1'b0;
    mem_write_en_o = 1'b0;
    mem_funct3_o   = 3'b000;
    case (state)
      S_IDLE: begin
        if (!rst) begin
          if (fetch_wins) begin
            if_gnt_o      = 1'b1;
            mem_addr_o    = if_addr_i;
            mem_read_en_o = 1'b1;
            mem_funct3_o  = 3'b010;
            state_nxt     = S_WAIT;
          end else if (d_req_i) begin
            d_gnt_o        = 1'b1;
            mem_addr_o     = d_addr_i;
            mem_data_o     = d_wdata_i;
            mem_funct3_o   = d_funct3_i;
            mem_write_en_o = d_we_i;
            mem_read_en_o  = !d_we_i;
            if (!d_we_i) state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt == 3'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Latency countdown and read-owner capture at issue time.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_cnt    <= 3'd0;
      owner_data <= 1'b0;
    end else if (read_issue) begin
      lat_cnt    <= LAT_INIT;
      owner_data <= d_gnt_o;
    end else if ((state == S_WAIT) && (lat_cnt != 3'd0)) begin
      lat_cnt <= lat_cnt - 3'd1;
    end
  end

  // Read-data capture and one-cycle rvalid pulse to the owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_o     <= '0;
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
    end else begin
      if_rvalid_o <= 1'b0;
      d_rvalid_o  <= 1'b0;
      if (read_done) begin
        rdata_o     <= mem_data_i;
        if_rvalid_o <= !owner_data;
        d_rvalid_o  <= owner_data;
      end
    end
  end

  // Fetch starvation counter: counts data grants taken while fetch waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt <= 4'd0;
    end else if (d_gnt_o && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. u_dut uses MEM_LATENCY=1,
// u_dut3 uses MEM_LATENCY=3; both see the same request stimulus.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [2:0]  d_funct3;
  logic [31:0] mem_data;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, rd_en, wr_en, busy;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [2:0]  mem_f3;

  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, rd_en3, wr_en3, busy3;
  logic [31:0] rdata3, mem_addr3, mem_wdata3;
  logic [2:0]  mem_f3_3;

  int vecs = 0;
  int errs = 0;

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt), .if_rvalid_o(if_rvalid),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_data_o(mem_wdata), .mem_read_en_o(rd_en),
    .mem_write_en_o(wr_en), .mem_funct3_o(mem_f3), .mem_data_i(mem_data), .busy_o(busy)
  );

  mem_port_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt3), .if_rvalid_o(if_rvalid3),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_funct3_i(d_funct3), .d_gnt_o(d_gnt3), .d_rvalid_o(d_rvalid3), .rdata_o(rdata3),
    .mem_addr_o(mem_addr3), .mem_data_o(mem_wdata3), .mem_read_en_o(rd_en3),
    .mem_write_en_o(wr_en3), .mem_funct3_o(mem_f3_3), .mem_data_i(mem_data), .busy_o(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge; inputs are driven here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req   = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_funct3 = 3'b000;
    d_wdata  = 32'h0;
    mem_data = 32'h0;
  endtask

  task automatic test_reset();
    logic [109:0] all_out;
    rst = 1'b1;
    step();
    if_req = 1'b1;
    d_req  = 1'b1;
    step();
    #1;
    all_out = {if_gnt, if_rvalid, d_gnt, d_rvalid, busy, rd_en, wr_en, mem_f3,
               mem_addr, mem_wdata, rdata};
    if (all_out !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    vecs++;
    all_out = {if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, busy3, rd_en3, wr_en3, mem_f3_3,
               mem_addr3, mem_wdata3, rdata3};
    if (all_out !== '0) begin errs++; $display("FAIL reset_outputs_lat3: got %h want 0", all_out); end
    vecs++;
    step();
    rst = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_fetch_only();
    step();
    if_req  = 1'b1;
    if_addr = 32'h0100_0000;
    #1;
    if ({if_gnt, d_gnt, rd_en, wr_en} !== 4'b1010) begin
      errs++; $display("FAIL fetch_gnt: got gnt/dgnt/rd/wr=%b want 1010", {if_gnt, d_gnt, rd_en, wr_en});
    end
    vecs++;
    if ({mem_f3, mem_addr, mem_wdata} !== {3'b010, 32'h0100_0000, 32'h0}) begin
      errs++; $display("FAIL fetch_port: got f3=%b addr=%h data=%h want 010 01000000 0", mem_f3, mem_addr, mem_wdata);
    end
    vecs++;
    step();
    if_req   = 1'b0;
    mem_data = 32'h0000_0013;
    #1;
    if ({busy, if_gnt, d_gnt, if_rvalid} !== 4'b1000) begin
      errs++; $display("FAIL fetch_wait: got busy/gnt/dgnt/rv=%b want 1000", {busy, if_gnt, d_gnt, if_rvalid});
    end
    vecs++;
    step();
    mem_data = 32'hFFFF_FFFF;
    #1;
    if ({if_rvalid, d_rvalid, busy, rdata} !== {3'b100, 32'h0000_0013}) begin
      errs++; $display("FAIL fetch_rvalid: got rv=%b drv=%b busy=%b rdata=%h want 1 0 0 00000013", if_rvalid, d_rvalid, busy, rdata);
    end
    vecs++;
    step();
    #1;
    if ({if_rvalid, rdata} !== {1'b0, 32'h0000_0013}) begin
      errs++; $display("FAIL fetch_rvalid_pulse: got rv=%b rdata=%h want 0 00000013", if_rvalid, rdata);
    end
    vecs++;
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    step();
    if_req   = 1'b1;
    if_addr  = 32'h0100_0004;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 32'h0100_0100;
    d_funct3 = 3'b010;
    #1;
    if ({d_gnt, if_gnt, rd_en, mem_addr} !== {3'b101, 32'h0100_0100}) begin
      errs++; $display("FAIL simul_dgnt: got dgnt=%b gnt=%b rd=%b addr=%h want 1 0 1 01000100", d_gnt, if_gnt, rd_en, mem_addr);
    end
    vecs++;
    step();
    d_req    = 1'b0;
    mem_data = 32'hDEAD_BEEF;
    #1;
    if ({busy, if_gnt, d_gnt} !== 3'b100) begin
      errs++; $display("FAIL simul_holdoff: got busy/gnt/dgnt=%b want 100", {busy, if_gnt, d_gnt});
    end
    vecs++;
    step();
    mem_data = 32'h0;
    #1;
    if ({d_rvalid, if_rvalid, rdata} !== {2'b10, 32'hDEAD_BEEF}) begin
      errs++; $display("FAIL simul_drvalid: got drv=%b rv=%b rdata=%h want 1 0 deadbeef", d_rvalid, if_rvalid, rdata);
    end
    vecs++;
    if ({if_gnt, d_gnt, rd_en, mem_f3, mem_addr} !== {3'b101, 3'b010, 32'h0100_0004}) begin
      errs++; $display("FAIL simul_fetch_same_cycle: got gnt=%b dgnt=%b rd=%b f3=%b addr=%h want 1 0 1 010 01000004", if_gnt, d_gnt, rd_en, mem_f3, mem_addr);
    end
    vecs++;
    step();
    if_req   = 1'b0;
    mem_data = 32'h0010_0093;
    step();
    #1;
    if ({if_rvalid, d_rvalid, rdata} !== {2'b10, 32'h0010_0093}) begin
      errs++; $display("FAIL simul_fetch_rvalid: got rv=%b drv=%b rdata=%h want 1 0 00100093", if_rvalid, d_rvalid, rdata);
    end
    vecs++;
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      step();
      d_req    = 1'b1;
      d_we     = 1'b1;
      d_funct3 = 3'b000;
      d_wdata  = 32'h0000_00AB;
      d_addr   = 32'h0000_0200 + 32'(i);
      #1;
      if ({d_gnt, if_gnt, wr_en, rd_en, mem_f3, mem_wdata, mem_addr} !==
          {4'b1010, 3'b000, 32'h0000_00AB, 32'h0000_0200 + 32'(i)}) begin
        errs++; $display("FAIL store_%0d: got dgnt=%b wr=%b rd=%b data=%h addr=%h", i, d_gnt, wr_en, rd_en, mem_wdata, mem_addr);
      end
      vecs++;
      if ({if_rvalid, d_rvalid, busy} !== 3'b000) begin
        errs++; $display("FAIL store_norvalid_%0d: got rv/drv/busy=%b want 000", i, {if_rvalid, d_rvalid, busy});
      end
      vecs++;
    end
    step();
    idle_inputs();
    #1;
    if ({if_rvalid, d_rvalid, busy, wr_en, rd_en, mem_addr} !== '0) begin
      errs++; $display("FAIL store_after: got rv=%b drv=%b busy=%b wr=%b rd=%b addr=%h want all 0", if_rvalid, d_rvalid, busy, wr_en, rd_en, mem_addr);
    end
    vecs++;
  endtask

  task automatic test_starvation();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        step();
        if_req   = 1'b1;
        if_addr  = 32'h0100_0040;
        d_req    = 1'b1;
        d_we     = 1'b1;
        d_funct3 = 3'b010;
        d_wdata  = 32'h0000_1000 + 32'(i);
        d_addr   = 32'h0000_0300 + 32'(4 * i);
        #1;
        if ({d_gnt, if_gnt} !== 2'b10) begin
          errs++; $display("FAIL starve_dgrant_r%0d_%0d: got dgnt/gnt=%b want 10", r, i, {d_gnt, if_gnt});
        end
        vecs++;
        if (r == 1 && i == 0 && if_rvalid !== 1'b1) begin
          errs++; $display("FAIL starve_fetch_rvalid: got %b want 1", if_rvalid);
        end
        if (r == 1 && i == 0) vecs++;
      end
      step();
      #1;
      if ({if_gnt, d_gnt, rd_en, wr_en, mem_f3, mem_wdata, mem_addr} !==
          {4'b1010, 3'b010, 32'h0, 32'h0100_0040}) begin
        errs++; $display("FAIL starve_forced_fetch_r%0d: got gnt=%b dgnt=%b rd=%b wr=%b f3=%b data=%h addr=%h", r, if_gnt, d_gnt, rd_en, wr_en, mem_f3, mem_wdata, mem_addr);
      end
      vecs++;
      step();
      mem_data = 32'h0000_0B00 + 32'(r);
      #1;
      if ({busy, if_gnt, d_gnt} !== 3'b100) begin
        errs++; $display("FAIL starve_wait_r%0d: got busy/gnt/dgnt=%b want 100", r, {busy, if_gnt, d_gnt});
      end
      vecs++;
    end
    step();
    idle_inputs();
    #1;
    if ({if_rvalid, rdata} !== {1'b1, 32'h0000_0B01}) begin
      errs++; $display("FAIL starve_last_rvalid: got rv=%b rdata=%h want 1 00000b01", if_rvalid, rdata);
    end
    vecs++;
    step();
  endtask

  task automatic test_latency_sweep();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 32'h0000_0400;
    d_funct3 = 3'b100;
    mem_data = 32'hFFFF_FFFF;
    #1;
    if ({d_gnt3, if_gnt3, rd_en3, mem_f3_3} !== {3'b101, 3'b100}) begin
      errs++; $display("FAIL lat3_grant: got dgnt=%b gnt=%b rd=%b f3=%b want 1 0 1 100", d_gnt3, if_gnt3, rd_en3, mem_f3_3);
    end
    vecs++;
    for (int k = 1; k <= 3; k++) begin
      step();
      if_req   = 1'b1;
      if_addr  = 32'h0100_0080;
      d_req    = (k == 2);
      mem_data = (k == 3) ? 32'h0000_0055 : 32'hFFFF_FFFF;
      #1;
      if ({busy3, if_gnt3, d_gnt3, d_rvalid3, if_rvalid3} !== 5'b10000) begin
        errs++; $display("FAIL lat3_wait_T%0d: got busy/gnt/dgnt/drv/rv=%b want 10000", k, {busy3, if_gnt3, d_gnt3, d_rvalid3, if_rvalid3});
      end
      vecs++;
    end
    step();
    d_req    = 1'b0;
    mem_data = 32'hFFFF_FFFF;
    #1;
    if ({d_rvalid3, if_rvalid3, busy3, rdata3} !== {3'b100, 32'h0000_0055}) begin
      errs++; $display("FAIL lat3_rvalid: got drv=%b rv=%b busy=%b rdata=%h want 1 0 0 00000055", d_rvalid3, if_rvalid3, busy3, rdata3);
    end
    vecs++;
    if (if_gnt3 !== 1'b1) begin
      errs++; $display("FAIL lat3_held_fetch_gnt: got %b want 1", if_gnt3);
    end
    vecs++;
    step();
    if_req = 1'b0;
    #1;
    if (d_rvalid3 !== 1'b0) begin
      errs++; $display("FAIL lat3_rvalid_pulse: got %b want 0", d_rvalid3);
    end
    vecs++;
    for (int k = 0; k < 4; k++) step();
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    step();
    if_req  = 1'b1;
    if_addr = 32'h0100_00C0;
    #1;
    if (if_gnt !== 1'b1) begin
      errs++; $display("FAIL rstmid_gnt: got %b want 1", if_gnt);
    end
    vecs++;
    step();
    rst      = 1'b1;
    if_req   = 1'b0;
    mem_data = 32'h0000_1234;
    step();
    rst = 1'b0;
    #1;
    if ({if_gnt, if_rvalid, d_gnt, d_rvalid, busy, rd_en, wr_en, mem_f3, mem_addr, mem_wdata, rdata} !== '0) begin
      errs++; $display("FAIL rstmid_outputs: got rv=%b busy=%b rdata=%h gnt=%b want all 0", if_rvalid, busy, rdata, if_gnt);
    end
    vecs++;
    step();
    #1;
    if ({if_rvalid, rdata} !== 33'h0) begin
      errs++; $display("FAIL rstmid_no_rvalid: got rv=%b rdata=%h want 0 0", if_rvalid, rdata);
    end
    vecs++;
    if_req  = 1'b1;
    if_addr = 32'h0100_00C4;
    #1;
    if ({if_gnt, mem_addr} !== {1'b1, 32'h0100_00C4}) begin
      errs++; $display("FAIL rstmid_regrant: got gnt=%b addr=%h want 1 010000c4", if_gnt, mem_addr);
    end
    vecs++;
    step();
    if_req   = 1'b0;
    mem_data = 32'h0000_0077;
    step();
    #1;
    if ({if_rvalid, rdata} !== {1'b1, 32'h0000_0077}) begin
      errs++; $display("FAIL rstmid_recover: got rv=%b rdata=%h want 1 00000077", if_rvalid, rdata);
    end
    vecs++;
    idle_inputs();
    step();
  endtask

  initial begin
    rst     = 1'b1;
    if_addr = 32'h0;
    d_addr  = 32'h0;
    idle_inputs();
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_latency_sweep();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
